// File: rtl/tetris_pkg.sv
// Shared types for the TETRIS round sequencer:
// shape codes, legality table, FSM states.
package tetris_pkg;

  localparam int PPR_DEF = 16;

  localparam logic [2:0] SH0 = 3'd0;
  localparam logic [2:0] SH1 = 3'd1;
  localparam logic [2:0] SH2 = 3'd2;
  localparam logic [2:0] SH3 = 3'd3;
  localparam logic [2:0] SH4 = 3'd4;
  localparam logic [2:0] SH5 = 3'd5;
  localparam logic [2:0] SH6 = 3'd6;
  localparam logic [2:0] SH7 = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic [2:0] shape;
    logic [2:0] pos;
  } piece_t;

  // Rightmost legal leftmost-column per shape on a 6-wide board.
  function automatic logic [2:0] max_pos(
    input logic [2:0] shape
  );
    logic [2:0] m;
    m = 3'd0;
    unique case (shape)
      SH0: m = 3'd4;
      SH1: m = 3'd5;
      SH2: m = 3'd2;
      SH3: m = 3'd4;
      SH4: m = 3'd3;
      SH5: m = 3'd4;
      SH6: m = 3'd4;
      SH7: m = 3'd3;
    endcase
    return m;
  endfunction

  function automatic logic is_legal(
    input piece_t p
  );
    return p.pos <= max_pos(p.shape);
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// Synchronous FIFO holding pending piece commands.
// Ports: i_push/i_data in, i_pop/o_data out, o_full, o_empty.
module piece_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wp[AW-1:0]] <= i_data;
        r_wp <= r_wp + (AW+1)'(1);
      end
      if (i_pop && !o_empty) r_rp <= r_rp + (AW+1)'(1);
    end
  end

  assign o_data  = r_mem[r_rp[AW-1:0]];
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);

endmodule

// File: rtl/tetris_round_ctrl.sv
// Round sequencer: buffers piece commands, checks legality, issues one
// piece at a time to the engine, counts rounds and reports summaries.
// Ports: req_* command in, eng_* engine side, round_* summary, timeout_err.
module tetris_round_ctrl
  import tetris_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int PIECES_PER_ROUND = PPR_DEF,
  parameter int TIMEOUT          = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_shape,
  input  logic [2:0] req_pos,
  output logic       eng_in_valid,
  output logic [2:0] eng_tetrominoes,
  output logic [2:0] eng_position,
  input  logic       eng_score_valid,
  input  logic       eng_fail,
  input  logic [3:0] eng_score,
  output logic       round_done,
  output logic       round_fail,
  output logic [3:0] round_score,
  output logic [4:0] round_illegal,
  output logic       timeout_err
);

  localparam int         WW   = $clog2(TIMEOUT + 1);
  localparam logic [4:0] PPR  = 5'(PIECES_PER_ROUND);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

  state_t        r_state;
  logic          r_rdy_en;
  logic [4:0]    r_piece_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic          r_fail;
  logic [3:0]    r_score;
  logic [4:0]    r_illegal;
  logic          r_timeout;
  logic          r_eng_v;
  logic [2:0]    r_eng_tet;
  logic [2:0]    r_eng_pos;
  logic          r_done;

  piece_t     w_head;
  logic [5:0] w_head_raw;
  logic       w_full;
  logic       w_empty;
  logic       w_ready;
  logic       w_acc;
  logic       w_push;
  logic       w_pop;
  logic       w_legal;
  logic       w_last;
  logic       w_to;
  logic [4:0] w_cnt_inc;
  logic [4:0] w_cnt_drain;
  logic [4:0] w_ill_inc;

  piece_fifo #(
    .DEPTH (DEPTH),
    .W     (6)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({req_shape, req_pos}),
    .i_pop   (w_pop),
    .o_data  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = piece_t'(w_head_raw);

  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_DRAIN:  w_ready = 1'b1;
      S_REPORT: w_ready = 1'b0;
      default:  w_ready = !w_full;
    endcase
    w_ready = w_ready & r_rdy_en;
  end

  assign w_acc   = req_valid && w_ready;
  // Commands accepted while draining are counted, never stored.
  assign w_push  = w_acc && (r_state != S_DRAIN);
  assign w_pop   = (r_state == S_ISSUE) ||
                   ((r_state == S_DRAIN) && !w_empty);
  assign w_legal = is_legal(w_head);
  assign w_last  = (r_piece_cnt == PPR);
  // A response in the final wait cycle wins over the timeout.
  assign w_to    = !eng_fail && !eng_score_valid &&
                   (r_wait_cnt == WMAX);

  assign w_cnt_inc   = r_piece_cnt + 5'd1;
  assign w_cnt_drain = r_piece_cnt +
                       5'(w_pop && (r_state == S_DRAIN)) +
                       5'(w_acc && (r_state == S_DRAIN));
  assign w_ill_inc   = (r_illegal == 5'd16) ? r_illegal
                                            : r_illegal + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rdy_en    <= 1'b0;
      r_piece_cnt <= '0;
      r_wait_cnt  <= '0;
      r_fail      <= 1'b0;
      r_score     <= '0;
      r_illegal   <= '0;
      r_timeout   <= 1'b0;
      r_eng_v     <= 1'b0;
      r_eng_tet   <= '0;
      r_eng_pos   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_eng_v  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            // Strobe is registered here so it lines up with ISSUE.
            r_state <= S_ISSUE;
            r_eng_v <= w_legal;
            if (w_legal) begin
              r_eng_tet <= w_head.shape;
              r_eng_pos <= w_head.pos;
            end
          end
        end
        S_ISSUE: begin
          r_piece_cnt <= w_cnt_inc;
          r_wait_cnt  <= '0;
          if (w_legal) begin
            r_state <= S_WAIT;
          end else begin
            r_illegal <= w_ill_inc;
            if (w_cnt_inc == PPR) begin
              r_state <= S_REPORT;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WW'(1);
          if (eng_score_valid) r_score <= eng_score;
          if (eng_fail || w_to) begin
            r_fail <= 1'b1;
            if (w_to) r_timeout <= 1'b1;
            if (w_last) begin
              r_state <= S_REPORT;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (eng_score_valid) begin
            if (w_last) begin
              r_state <= S_REPORT;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          r_piece_cnt <= w_cnt_drain;
          if (w_cnt_drain >= PPR) begin
            r_state <= S_REPORT;
            r_done  <= 1'b1;
          end
        end
        S_REPORT: begin
          r_piece_cnt <= '0;
          r_fail      <= 1'b0;
          r_illegal   <= '0;
          r_score     <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = w_ready;
  assign eng_in_valid    = r_eng_v;
  assign eng_tetrominoes = r_eng_tet;
  assign eng_position    = r_eng_pos;
  assign round_done      = r_done;
  assign round_fail      = r_fail;
  assign round_score     = r_score;
  assign round_illegal   = r_illegal;
  assign timeout_err     = r_timeout;

endmodule

// File: tb/tb_tetris_round_ctrl.sv
// Self-checking bench for tetris_round_ctrl: engine model,
// strobe/round scoreboards, table-driven legality round.
module tb_tetris_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_shape;
  logic [2:0] req_pos;
  logic       eng_in_valid;
  logic [2:0] eng_tetrominoes;
  logic [2:0] eng_position;
  logic       eng_score_valid;
  logic       eng_fail;
  logic [3:0] eng_score;
  logic       round_done;
  logic       round_fail;
  logic [3:0] round_score;
  logic [4:0] round_illegal;
  logic       timeout_err;

  always #5 clk = ~clk;

  tetris_round_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_shape       (req_shape),
    .req_pos         (req_pos),
    .eng_in_valid    (eng_in_valid),
    .eng_tetrominoes (eng_tetrominoes),
    .eng_position    (eng_position),
    .eng_score_valid (eng_score_valid),
    .eng_fail        (eng_fail),
    .eng_score       (eng_score),
    .round_done      (round_done),
    .round_fail      (round_fail),
    .round_score     (round_score),
    .round_illegal   (round_illegal),
    .timeout_err     (timeout_err)
  );

  typedef struct {
    logic [2:0] shape;
    logic [2:0] pos;
  } exp_pc_t;

  typedef struct {
    int fail;
    int score;
    int ill;
  } exp_rd_t;

  typedef struct {
    logic [2:0] shape;
    logic [2:0] pos;
    bit         legal;
  } vec_t;

  exp_pc_t exp_q[$];
  exp_rd_t rd_q[$];
  vec_t    vt[16];

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int strobes = 0;
  int dones = 0;
  int first_strobe_cyc = -1;
  int last_strobe_cyc = 0;
  int to_cyc = -1;

  int eng_delay = 3;
  int fail_at = 0;
  int silent_at = 0;
  int strobe_n = 0;
  logic [3:0] eng_sc = 4'd0;

  int n_acc = 0;
  int acc_cyc = 0;
  int stall_first = -1;
  bit track_stall = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_pc_t e;
    exp_rd_t r;
    cyc++;
    if (eng_in_valid) begin
      strobes++;
      last_strobe_cyc = cyc;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_fields", int'({eng_tetrominoes, eng_position}),
            int'({e.shape, e.pos}));
      end
    end
    if (round_done) begin
      dones++;
      if (rd_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        r = rd_q.pop_front();
        chk("round_fail", int'(round_fail), r.fail);
        chk("round_score", int'(round_score), r.score);
        chk("round_illegal", int'(round_illegal), r.ill);
      end
    end
    if (timeout_err && to_cyc < 0) to_cyc = cyc;
  end

  // Engine model: answers each strobe after eng_delay cycles.
  initial forever begin
    @(negedge clk);
    if (rst_n && eng_in_valid) begin
      strobe_n++;
      if (strobe_n != silent_at) begin
        repeat (eng_delay) @(negedge clk);
        if (strobe_n == fail_at) eng_fail = 1'b1;
        eng_sc++;
        eng_score = eng_sc;
        eng_score_valid = 1'b1;
        @(negedge clk);
        eng_fail = 1'b0;
        eng_score_valid = 1'b0;
      end
    end
  end

  task automatic send(input logic [2:0] sh, input logic [2:0] ps,
                      input bit issue);
    int w;
    exp_pc_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_shape = sh;
    req_pos = ps;
    #1;
    w = 0;
    while (!req_ready && w < 300) begin
      if (track_stall && stall_first < 0) stall_first = n_acc - strobes;
      @(negedge clk);
      #1;
      w++;
    end
    if (!req_ready) begin
      chk("send_accept", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n_acc++;
    acc_cyc = cyc;
    if (issue) begin
      e.shape = sh;
      e.pos = ps;
      exp_q.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic start_round(input int dly, input int fa, input int sa,
                             input int xf, input int xs, input int xi);
    exp_rd_t r;
    eng_delay = dly;
    fail_at = fa;
    silent_at = sa;
    strobe_n = 0;
    eng_sc = 4'd0;
    strobes = 0;
    first_strobe_cyc = -1;
    r.fail = xf;
    r.score = xs;
    r.ill = xi;
    rd_q.push_back(r);
  endtask

  task automatic wait_done(input int target, input string nm);
    int w;
    w = 0;
    while (dones < target && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk(nm, dones, target);
    repeat (3) @(negedge clk);
    chk({nm, "_sb"}, exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, int'(req_ready), 0);
    chk({nm, "_eng_v"}, int'(eng_in_valid), 0);
    chk({nm, "_eng_t"}, int'(eng_tetrominoes), 0);
    chk({nm, "_eng_p"}, int'(eng_position), 0);
    chk({nm, "_done"}, int'(round_done), 0);
    chk({nm, "_fail"}, int'(round_fail), 0);
    chk({nm, "_score"}, int'(round_score), 0);
    chk({nm, "_ill"}, int'(round_illegal), 0);
    chk({nm, "_to"}, int'(timeout_err), 0);
  endtask

  initial begin
    int fa;
    int w;
    req_valid = 1'b0;
    req_shape = 3'd0;
    req_pos = 3'd0;
    eng_score_valid = 1'b0;
    eng_fail = 1'b0;
    eng_score = 4'd0;

    // Each shape at its max column (legal) and one past it.
    vt[0]  = '{3'd0, 3'd4, 1'b1};
    vt[1]  = '{3'd0, 3'd5, 1'b0};
    vt[2]  = '{3'd1, 3'd5, 1'b1};
    vt[3]  = '{3'd1, 3'd6, 1'b0};
    vt[4]  = '{3'd2, 3'd2, 1'b1};
    vt[5]  = '{3'd2, 3'd3, 1'b0};
    vt[6]  = '{3'd3, 3'd4, 1'b1};
    vt[7]  = '{3'd3, 3'd5, 1'b0};
    vt[8]  = '{3'd4, 3'd3, 1'b1};
    vt[9]  = '{3'd4, 3'd4, 1'b0};
    vt[10] = '{3'd5, 3'd4, 1'b1};
    vt[11] = '{3'd5, 3'd5, 1'b0};
    vt[12] = '{3'd6, 3'd4, 1'b1};
    vt[13] = '{3'd6, 3'd5, 1'b0};
    vt[14] = '{3'd7, 3'd3, 1'b1};
    vt[15] = '{3'd7, 3'd4, 1'b0};

    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(req_ready), 1);

    // Sixteen legal pieces, score wraps to 0.
    start_round(3, 0, 0, 0, 0, 0);
    fa = 0;
    for (int i = 0; i < 16; i++) begin
      send(3'd2, 3'd0, 1'b1);
      if (i == 0) fa = acc_cyc;
    end
    wait_done(1, "t1_done");
    chk("t1_latency", first_strobe_cyc - fa, 2);
    chk("t1_strobes", strobes, 16);
    chk("t1_to", int'(timeout_err), 0);

    // Legality table round.
    start_round(1, 0, 0, 0, 8, 8);
    for (int i = 0; i < 16; i++) send(vt[i].shape, vt[i].pos, vt[i].legal);
    wait_done(2, "t2_done");
    chk("t2_strobes", strobes, 8);

    // Piece 5 illegal.
    start_round(3, 0, 0, 0, 15, 1);
    for (int i = 0; i < 16; i++)
      send(3'd2, (i == 4) ? 3'd4 : 3'd0, i != 4);
    wait_done(3, "t3_done");
    chk("t3_strobes", strobes, 15);

    // All illegal: counter reaches 16.
    start_round(3, 0, 0, 0, 0, 16);
    for (int i = 0; i < 16; i++) send(3'd1, 3'd6, 1'b0);
    wait_done(4, "t4_done");
    chk("t4_strobes", strobes, 0);

    // Fail with simultaneous score on piece 7, rest drained.
    start_round(3, 7, 0, 1, 7, 0);
    for (int i = 0; i < 16; i++) send(3'd0, 3'd0, i < 7);
    wait_done(5, "t5_done");
    chk("t5_strobes", strobes, 7);

    // Engine silent on piece 3.
    start_round(3, 0, 3, 1, 2, 0);
    for (int i = 0; i < 16; i++) send(3'd4, 3'd3, i < 3);
    wait_done(6, "t6_done");
    chk("t6_to", int'(timeout_err), 1);
    chk("t6_to_cycle", to_cyc - last_strobe_cyc, 17);
    chk("t6_strobes", strobes, 3);

    // Next round clean, timeout_err sticky.
    start_round(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(3'd3, 3'd4, 1'b1);
    wait_done(7, "t7_done");
    chk("t7_to_sticky", int'(timeout_err), 1);
    chk("t7_strobes", strobes, 16);

    // Back-to-back with slow engine: FIFO fills to 4.
    start_round(10, 0, 0, 0, 0, 0);
    n_acc = 0;
    stall_first = -1;
    track_stall = 1'b1;
    for (int i = 0; i < 16; i++) send(3'(i % 8), 3'(i % 3), 1'b1);
    track_stall = 1'b0;
    wait_done(8, "t8_done");
    chk("t8_fifo_depth", stall_first, 4);
    chk("t8_strobes", strobes, 16);

    // Reset while waiting on the engine.
    eng_delay = 3;
    fail_at = 0;
    silent_at = 1;
    strobe_n = 0;
    strobes = 0;
    send(3'd6, 3'd1, 1'b1);
    send(3'd6, 3'd2, 1'b0);
    send(3'd6, 3'd3, 1'b0);
    w = 0;
    while (strobes < 1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t9_pre_strobe", strobes, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("t9_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_round(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(3'd5, 3'd4, 1'b1);
    wait_done(9, "t9_done");
    chk("t9_strobes", strobes, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tetris_round_ctrl.md
# tetris_round_ctrl

Round sequencer between the piece-command source and the 6x12 TETRIS game engine. Buffers incoming piece commands, checks position legality per shape, issues one piece at a time to the engine, and waits for that piece's result before issuing the next. Counts 16-piece rounds, drains the rest of a round after an engine fail or a response timeout, and emits a one-cycle round summary.

## Interface
- DEPTH, 4: piece FIFO entries, power of two ≥2
- PIECES_PER_ROUND, 16: pieces per round
- TIMEOUT, 15: max cycles in WAIT before declaring an engine timeout

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  piece command valid
- req_ready  out  1  command accepted when req_valid&&req_ready
- req_shape  in  3  tetromino code 0..7
- req_pos  in  3  leftmost column
- eng_in_valid  out  1  one-cycle piece strobe to engine
- eng_tetrominoes  out  3  shape to engine
- eng_position  out  3  column to engine
- eng_score_valid  in  1  engine per-piece result strobe
- eng_fail  in  1  engine overflow strobe
- eng_score  in  4  engine cumulative round score, valid with eng_score_valid
- round_done  out  1  one-cycle round-end pulse
- round_fail  out  1  round ended by fail or timeout; valid with round_done
- round_score  out  4  last captured eng_score; valid with round_done
- round_illegal  out  5  illegal pieces dropped this round; valid with round_done
- timeout_err  out  1  sticky, set on any WAIT timeout, cleared only by reset

## Operation
- Legal max position per shape: 0:4, 1:5, 2:2, 3:4, 4:3, 5:4, 6:4, 7:3. Pieces with pos > max are illegal: dropped without engine access, round_illegal++, and counted toward the round.
- FSM states: IDLE, ISSUE, WAIT, DRAIN, REPORT.
- IDLE: FIFO non-empty -> ISSUE.
- ISSUE (one cycle): pop head; piece_cnt++.
  - Legal: eng_in_valid=1 with head fields; -> WAIT.
  - Illegal: -> REPORT if piece_cnt reaches PIECES_PER_ROUND, else IDLE.
- WAIT: wait_cnt counts up from 0.
  - eng_fail: fail_flag=1; -> REPORT if piece_cnt==PIECES_PER_ROUND, else DRAIN. eng_fail has priority over a simultaneous eng_score_valid, but eng_score is still captured.
  - eng_score_valid alone: capture eng_score; -> REPORT if piece_cnt==PIECES_PER_ROUND, else IDLE.
  - wait_cnt==TIMEOUT: timeout_err=1, fail_flag=1; handled as eng_fail.
- DRAIN: flush the FIFO at one entry per cycle. req_ready=1 and accepted commands are discarded. Each discarded piece does piece_cnt++. When piece_cnt==PIECES_PER_ROUND -> REPORT.
- REPORT (one cycle): round_done=1 and round_* outputs driven. Then piece_cnt, fail_flag, round_illegal and score clear; -> IDLE.
- eng_score_valid/eng_fail outside WAIT are ignored.
- Counters: piece_cnt is 5 bit; wait_cnt is ceil(log2(TIMEOUT+1)) bits; round_illegal saturates at 16.

## Timing
- Reset values: req_ready=0, eng_in_valid=0, eng_tetrominoes=0, eng_position=0, round_done=0, round_fail=0, round_score=0, round_illegal=0, timeout_err=0, state IDLE, FIFO empty. req_ready goes high the first cycle after reset release.
- req_ready = !fifo_full in IDLE/ISSUE/WAIT, 1 in DRAIN, 0 in REPORT. No full-FIFO bypass: a push and a pop in the same cycle on a full FIFO is not possible because ready=0.
- Latency: command accepted in cycle c into an empty FIFO with FSM in IDLE -> eng_in_valid high in cycle c+2.
- Minimum issue spacing: eng_score_valid in cycle w -> next eng_in_valid no earlier than w+2.
- round_done is asserted the cycle after the round-ending event.
- Reset mid-round: all state is lost, nothing is reported, and the engine shares the same rst_n.

## Structure
- Package tetris_pkg: shape code constants, max-position table, PIECES_PER_ROUND default, FSM state enum.
- Sub-module piece_fifo: synchronous FIFO, DEPTH x 6 bits, with push/pop/full/empty.
- The FSM, counters and legality check stay in tetris_round_ctrl.

## Test plan
- Sixteen legal pieces (shape 2, pos 0), engine answers with eng_score_valid 3 cycles after each strobe and score 1..16 wrapping to 0 -> 16 strobes, round_done once, round_fail=0, round_score=0, round_illegal=0.
- Piece 5 is shape 2 pos 4 (illegal), the rest legal -> 15 strobes, round_illegal=1, round_done after the 16th piece.
- eng_fail on piece 7, upstream keeps sending 9 more -> no further strobes, all 9 accepted in DRAIN, round_done with round_fail=1.
- Engine silent after a strobe -> timeout_err=1 at wait_cnt=15, then DRAIN, round_fail=1; timeout_err stays set through the next round.
- Back-to-back req_valid with an engine responding after 10 cycles -> req_ready drops after 4 pending commands, no command lost or reordered.
- rst_n asserted in WAIT -> all outputs 0 immediately; the next round starts cleanly with piece_cnt=0.
